// File: rtl/dll_dlcmsm_mvc.sv
// dll_dlcmsm_mvc
// Data Link Control & Management state machine for a multi-VC link.
// Follows the physical link state and runs flow-control initialisation
// (InitFC1, then InitFC2) across the enabled VCs. While initialising it
// asks the DLLP generator for InitFC sets, one VC at a time, and repeats
// the request pass on a resend timer until the phase completes.
//
// Optional feature exchange: define DLL_FEATURE_EXCH_EN to add a FEATURE
// state between INACTIVE and INIT1, along with the feat_* ports.
//
// Parameters
//   NUM_VC         number of VCs (1..8); VC0 is always enabled
//   RESEND_CYCLES  interval between request passes, in clk cycles (>=2)
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   link_up_i             physical link is up
//   vc_en_i               VC enable mask, sampled when the link comes up
//   fc1_rcvd_i            per-VC pulse: InitFC1 set received
//   fc2_rcvd_i            per-VC pulse: InitFC2 or UpdateFC received
//   tx_init_req_o/vc/phase  InitFC send request to the DLLP generator
//   tx_init_ack_i         generator accepted the request (req & ack)
//   state_o               0 INACTIVE, 1 FEATURE, 2 INIT1, 3 INIT2, 4 ACTIVE
//   dl_up_o               link layer active
//   dl_down_pulse_o       one-cycle pulse when ACTIVE is lost
//   vc_active_o           per-VC flow-control init complete
//   feat_rcvd_i, feat_req_o, feat_ack_i   (DLL_FEATURE_EXCH_EN only)
//
// state    | meaning
// INACTIVE | link down, nothing scheduled
// FEATURE  | feature exchange in progress (optional build)
// INIT1    | exchanging InitFC1 on every enabled VC
// INIT2    | exchanging InitFC2 on every enabled VC
// ACTIVE   | flow control initialised, dl_up asserted
module dll_dlcmsm_mvc #(
    parameter int NUM_VC        = 1,
    parameter int RESEND_CYCLES = 8500,
    localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int TMR_W = $clog2(RESEND_CYCLES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              link_up_i,
    input  logic [NUM_VC-1:0] vc_en_i,
    input  logic [NUM_VC-1:0] fc1_rcvd_i,
    input  logic [NUM_VC-1:0] fc2_rcvd_i,
    output logic              tx_init_req_o,
    output logic [VC_W-1:0]   tx_init_vc_o,
    output logic              tx_init_phase_o,
    input  logic              tx_init_ack_i,
    output logic [2:0]        state_o,
    output logic              dl_up_o,
    output logic              dl_down_pulse_o,
    output logic [NUM_VC-1:0] vc_active_o
`ifdef DLL_FEATURE_EXCH_EN
    ,
    input  logic              feat_rcvd_i,
    output logic              feat_req_o,
    input  logic              feat_ack_i
`endif
);

    typedef enum logic [2:0] {
        ST_INACTIVE = 3'd0,
        ST_FEATURE  = 3'd1,
        ST_INIT1    = 3'd2,
        ST_INIT2    = 3'd3,
        ST_ACTIVE   = 3'd4
    } state_t;

    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RESEND_CYCLES - 1);

    state_t              state, state_nxt;
    logic [NUM_VC-1:0]   mask, mask_nxt;
    logic [NUM_VC-1:0]   rx, rx_nxt;
    logic [NUM_VC-1:0]   tx, tx_nxt;
    logic                req, req_nxt;
    logic [VC_W-1:0]     vc, vc_nxt;
    logic                phase, phase_nxt;
    logic [TMR_W-1:0]    timer, timer_nxt;
    logic                dl_up, dl_up_nxt;
    logic                dl_down, dl_down_nxt;
    logic [NUM_VC-1:0]   vc_active, vc_active_nxt;

    logic [NUM_VC-1:0]   vc_onehot;
    logic [VC_W-1:0]     vc_next;
    logic                vc_found;
    logic [NUM_VC-1:0]   fc_pulse, rx_upd, tx_upd;
    logic                xfer, init_done;

`ifdef DLL_FEATURE_EXCH_EN
    logic feat_req, feat_req_nxt;
    logic feat_rcvd, feat_rcvd_nxt;
    logic feat_acked, feat_acked_nxt;
    logic feat_xfer;
    assign feat_req_o = feat_req;
    assign feat_xfer  = feat_req & feat_ack_i;
`endif

    assign tx_init_req_o   = req;
    assign tx_init_vc_o    = vc;
    assign tx_init_phase_o = phase;
    assign state_o         = state;
    assign dl_up_o         = dl_up;
    assign dl_down_pulse_o = dl_down;
    assign vc_active_o     = vc_active;

    // Next enabled VC strictly above the one being requested; searching
    // downward leaves the lowest qualifying index in vc_next.
    always_comb begin
        vc_found = 1'b0;
        vc_next  = '0;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (mask[i] && (VC_W'(i) > vc)) begin
                vc_found = 1'b1;
                vc_next  = VC_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            vc_onehot[i] = (vc == VC_W'(i));
        end
    end

    // Flag updates include this cycle's pulse and transfer, so a phase can
    // complete on the same edge that delivers its last event.
    assign xfer      = req & tx_init_ack_i;
    assign fc_pulse  = (state == ST_INIT2) ? fc2_rcvd_i : fc1_rcvd_i;
    assign rx_upd    = rx | (fc_pulse & mask);
    assign tx_upd    = tx | ({NUM_VC{xfer}} & vc_onehot & mask);
    assign init_done = &((rx_upd & tx_upd) | ~mask);

    always_comb begin
        state_nxt   = state;
        mask_nxt    = mask;
        rx_nxt      = rx;
        tx_nxt      = tx;
        req_nxt     = req;
        vc_nxt      = vc;
        phase_nxt   = phase;
        timer_nxt   = timer;
        dl_down_nxt = 1'b0;
`ifdef DLL_FEATURE_EXCH_EN
        feat_req_nxt   = feat_req;
        feat_rcvd_nxt  = feat_rcvd;
        feat_acked_nxt = feat_acked;
`endif

        case (state)
            ST_INACTIVE: begin
                if (link_up_i) begin
                    mask_nxt  = vc_en_i | NUM_VC'(1);
                    rx_nxt    = '0;
                    tx_nxt    = '0;
                    vc_nxt    = '0;
                    phase_nxt = 1'b0;
                    timer_nxt = '0;
`ifdef DLL_FEATURE_EXCH_EN
                    state_nxt      = ST_FEATURE;
                    feat_req_nxt   = 1'b1;
                    feat_rcvd_nxt  = 1'b0;
                    feat_acked_nxt = 1'b0;
`else
                    state_nxt = ST_INIT1;
                    req_nxt   = 1'b1;
`endif
                end
            end

`ifdef DLL_FEATURE_EXCH_EN
            ST_FEATURE: begin
                feat_rcvd_nxt  = feat_rcvd | feat_rcvd_i;
                feat_acked_nxt = feat_acked | feat_xfer;
                if (feat_xfer) begin
                    feat_req_nxt = 1'b0;
                    timer_nxt    = TMR_LOAD;
                end else if (!feat_req) begin
                    if (timer == '0) feat_req_nxt = 1'b1;
                    else             timer_nxt    = timer - TMR_W'(1);
                end
                // Never withdraw an outstanding feature request.
                if (feat_rcvd_nxt && feat_acked_nxt && !(feat_req && !feat_ack_i)) begin
                    state_nxt      = ST_INIT1;
                    feat_req_nxt   = 1'b0;
                    feat_rcvd_nxt  = 1'b0;
                    feat_acked_nxt = 1'b0;
                    req_nxt        = 1'b1;
                    vc_nxt         = '0;
                    phase_nxt      = 1'b0;
                    timer_nxt      = '0;
                end
            end
`endif

            ST_INIT1, ST_INIT2: begin
                rx_nxt = rx_upd;
                tx_nxt = tx_upd;
                if (xfer) begin
                    if (vc_found) begin
                        vc_nxt = vc_next;
                    end else begin
                        req_nxt   = 1'b0;
                        timer_nxt = TMR_LOAD;
                    end
                end else if (!req) begin
                    if (timer == '0) begin
                        req_nxt = 1'b1;
                        vc_nxt  = '0;
                    end else begin
                        timer_nxt = timer - TMR_W'(1);
                    end
                end
                // Advance only when no request is left hanging unacknowledged.
                if (init_done && !(req && !tx_init_ack_i)) begin
                    rx_nxt    = '0;
                    tx_nxt    = '0;
                    timer_nxt = '0;
                    vc_nxt    = '0;
                    if (state == ST_INIT1) begin
                        state_nxt = ST_INIT2;
                        req_nxt   = 1'b1;
                        phase_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_ACTIVE;
                        req_nxt   = 1'b0;
                        phase_nxt = 1'b0;
                    end
                end
            end

            ST_ACTIVE: begin
                req_nxt = 1'b0;
            end

            default: begin
                state_nxt = ST_INACTIVE;
            end
        endcase

        if ((state != ST_INACTIVE) && !link_up_i) begin
            state_nxt   = ST_INACTIVE;
            rx_nxt      = '0;
            tx_nxt      = '0;
            req_nxt     = 1'b0;
            vc_nxt      = '0;
            phase_nxt   = 1'b0;
            timer_nxt   = '0;
            dl_down_nxt = (state == ST_ACTIVE);
`ifdef DLL_FEATURE_EXCH_EN
            feat_req_nxt   = 1'b0;
            feat_rcvd_nxt  = 1'b0;
            feat_acked_nxt = 1'b0;
`endif
        end

        dl_up_nxt     = (state_nxt == ST_ACTIVE);
        vc_active_nxt = (state_nxt == ST_ACTIVE) ? mask_nxt : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INACTIVE;
            mask      <= NUM_VC'(1);
            rx        <= '0;
            tx        <= '0;
            req       <= 1'b0;
            vc        <= '0;
            phase     <= 1'b0;
            timer     <= '0;
            dl_up     <= 1'b0;
            dl_down   <= 1'b0;
            vc_active <= '0;
        end else begin
            state     <= state_nxt;
            mask      <= mask_nxt;
            rx        <= rx_nxt;
            tx        <= tx_nxt;
            req       <= req_nxt;
            vc        <= vc_nxt;
            phase     <= phase_nxt;
            timer     <= timer_nxt;
            dl_up     <= dl_up_nxt;
            dl_down   <= dl_down_nxt;
            vc_active <= vc_active_nxt;
        end
    end

`ifdef DLL_FEATURE_EXCH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_req   <= 1'b0;
            feat_rcvd  <= 1'b0;
            feat_acked <= 1'b0;
        end else begin
            feat_req   <= feat_req_nxt;
            feat_rcvd  <= feat_rcvd_nxt;
            feat_acked <= feat_acked_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_dll_dlcmsm_mvc.sv
// Testbench for dll_dlcmsm_mvc (NUM_VC=4, RESEND_CYCLES=16).
// A queue-based model of the link state and request passes predicts the
// outputs; a negedge process compares every cycle, and directed scenarios
// add hand-computed literal checks.
`timescale 1ns/1ps
module tb_dll_dlcmsm_mvc;
    localparam int NV = 4;
    localparam int RS = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic link_up = 1'b0;
    logic [NV-1:0] vc_en = '0;
    logic [NV-1:0] fc1 = '0;
    logic [NV-1:0] fc2 = '0;
    logic ack = 1'b0;
    logic req;
    logic [1:0] vc;
    logic phase;
    logic [2:0] st;
    logic dl_up, dl_dn;
    logic [NV-1:0] va;

    always #5 clk = ~clk;

    dll_dlcmsm_mvc #(.NUM_VC(NV), .RESEND_CYCLES(RS)) dut (
        .clk(clk), .rst_n(rst_n), .link_up_i(link_up), .vc_en_i(vc_en),
        .fc1_rcvd_i(fc1), .fc2_rcvd_i(fc2),
        .tx_init_req_o(req), .tx_init_vc_o(vc), .tx_init_phase_o(phase),
        .tx_init_ack_i(ack), .state_o(st), .dl_up_o(dl_up),
        .dl_down_pulse_o(dl_dn), .vc_active_o(va)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // ---------------- behavioural model ----------------
    // m_st: 0 inactive, 2 init1, 3 init2, 4 active. q holds the VCs still
    // to be requested in the current pass; an empty q means waiting for the
    // resend edge m_next.
    int       m_st = 0;
    bit [3:0] m_mask = 4'b0001;
    bit [3:0] m_rx = 0, m_tx = 0;
    int       q[$];
    longint   m_edge = 0;
    longint   m_next = 0;
    bit       m_dd = 0;

    function automatic void start_pass();
        q.delete();
        for (int i = 0; i < NV; i++) if (m_mask[i]) q.push_back(i);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit had, xfer;
        if (!rst_n) begin
            m_st = 0; m_mask = 4'b0001; m_rx = 0; m_tx = 0;
            q.delete(); m_dd = 0; m_next = 0;
        end else begin
            m_edge++;
            m_dd = 0;
            if (m_st != 0 && !link_up) begin
                m_dd = (m_st == 4);
                m_st = 0; q.delete(); m_rx = 0; m_tx = 0;
            end else if (m_st == 0) begin
                if (link_up) begin
                    m_mask = vc_en | 4'b0001;
                    m_st = 2; m_rx = 0; m_tx = 0;
                    start_pass();
                end
            end else if (m_st == 2 || m_st == 3) begin
                had  = (q.size() > 0);
                xfer = had && ack;
                m_rx |= ((m_st == 2) ? fc1 : fc2) & m_mask;
                if (xfer) begin
                    m_tx[q[0]] = 1'b1;
                    void'(q.pop_front());
                    if (q.size() == 0) m_next = m_edge + RS;
                end else if (!had && m_edge == m_next) begin
                    start_pass();
                end
                if (((m_rx & m_tx) & m_mask) == m_mask && !(had && !ack)) begin
                    m_rx = 0; m_tx = 0;
                    if (m_st == 2) begin m_st = 3; start_pass(); end
                    else begin m_st = 4; q.delete(); end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit       e_req;
        bit [1:0] e_vc;
        bit       e_ph;
        logic [12:0] e_pk, a_pk;
        if (cmp_en) begin
            e_req = (m_st == 2 || m_st == 3) && (q.size() > 0);
            e_vc  = e_req ? 2'(q[0]) : 2'd0;
            e_ph  = e_req ? (m_st == 3) : 1'b0;
            e_pk  = {e_req, e_vc, e_ph, 3'(m_st), (m_st == 4), m_dd,
                     (m_st == 4) ? m_mask : 4'b0000};
            a_pk  = {req, req ? vc : 2'd0, req ? phase : 1'b0, st, dl_up, dl_dn, va};
            n_cmp++;
            if (a_pk !== e_pk) begin
                n_bad++;
                $display("FAIL cycle_model t=%0t got {req,vc,ph,st,up,dn,va}=%b expected %b",
                         $time, a_pk, e_pk);
            end
        end
    end

    // ---------------- ack responder ----------------
    int ncyc = 0;
    int last_ack = -100;
    int ack_delay = 0;
    int wait_cnt = 0;
    always @(negedge clk) begin
        ncyc++;
        if (req === 1'b1) begin
            if (wait_cnt >= ack_delay) begin
                ack = 1'b1; wait_cnt = 0; last_ack = ncyc;
            end else begin
                ack = 1'b0; wait_cnt++;
            end
        end else begin
            ack = 1'b0; wait_cnt = 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic wait_req(input string name, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (req === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: got no request expected one within %0d cycles", name, maxc);
        end
    endtask

    initial begin
        int t_last;
        bit ok;
        bit seen;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        tick();
        chk("rst_state", st, 0);
        chk("rst_req", req, 0);
        chk("rst_dl_up", dl_up, 0);
        chk("rst_vc_active", va, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // T1: single enabled VC, full init to ACTIVE
        vc_en = 4'b0001; link_up = 1'b1;
        tick();
        chk("t1_init1", st, 2);
        chk("t1_req", req, 1);
        repeat (9) tick();
        fc1 = 4'b0001; tick(); fc1 = '0;
        chk("t1_init2", st, 3);
        chk("t1_phase2", phase, 1);
        repeat (4) tick();
        fc2 = 4'b0001; tick(); fc2 = '0;
        chk("t1_active", st, 4);
        chk("t1_dl_up", dl_up, 1);
        chk("t1_vc_active", va, 1);
        chk("t1_no_req", req, 0);

        // T4: link drop from ACTIVE
        link_up = 1'b0; tick();
        chk("t4_state", st, 0);
        chk("t4_dl_up", dl_up, 0);
        chk("t4_down_pulse", dl_dn, 1);
        tick();
        chk("t4_down_pulse_end", dl_dn, 0);

        // T2/T3: relink with vc_en=0101, three resend passes
        vc_en = 4'b0101; link_up = 1'b1;
        tick();
        chk("t4_relink_init1", st, 2);
        chk("t2_first_vc", vc, 0);
        chk("t2_first_phase", phase, 0);
        tick();
        chk("t2_second_vc", vc, 2);
        t_last = last_ack;
        for (int p = 0; p < 3; p++) begin
            wait_req("t3_resend", 40, ok);
            if (!ok) break;
            chk("t3_resend_gap", ncyc - t_last, 17);
            chk("t3_pass_vc0", vc, 0);
            tick();
            chk("t3_pass_vc2", vc, 2);
            t_last = last_ack;
        end
        tick();
        fc1 = 4'b1111; tick(); fc1 = '0;
        chk("t2_init2", st, 3);
        repeat (3) tick();
        fc2 = 4'b1010; tick(); fc2 = '0;
        chk("t2_disabled_fc2_ignored", st, 3);
        fc2 = 4'b0101; tick(); fc2 = '0;
        chk("t2_active", st, 4);
        chk("t2_vc_active", va, 5);

        // T5: phase completion deferred behind an unacked resend request
        link_up = 1'b0; tick();
        vc_en = 4'b0001; link_up = 1'b1; tick();
        chk("t5_init1", st, 2);
        ack_delay = 5;
        wait_req("t5_resend", 40, ok);
        fc1 = 4'b0001; tick(); fc1 = '0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (st == 3'd3) begin seen = 1'b1; break; end
            chk("t5_hold_init1", st, 2);
            tick();
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL t5_to_init2: got state %0d expected 3 within 12 cycles", st);
        end else begin
            chk("t5_init2_after_ack", ncyc - last_ack, 1);
            chk("t5_init2_req", req, 1);
            chk("t5_init2_phase", phase, 1);
        end

        // T6: async reset in the middle of INIT2
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_state", st, 0);
        chk("t6_req", req, 0);
        chk("t6_phase", phase, 0);
        chk("t6_dl_up", dl_up, 0);
        chk("t6_vc_active", va, 0);
        vc_en = 4'b0010; ack_delay = 0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_relatch_init1", st, 2);
        chk("t6_relatch_vc0", vc, 0);
        tick();
        chk("t6_relatch_vc1", vc, 1);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
